// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: opcodes, state encoding and datapath select encodings shared with the datapath
package multicycle_ctrl_pkg;
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J = 6'h02;
  localparam logic [5:0] OPC_JAL = 6'h03;
  localparam logic [5:0] OPC_BEQ = 6'h04;
  localparam logic [5:0] OPC_ADDI = 6'h08;
  localparam logic [5:0] OPC_SLTI = 6'h0A;
  localparam logic [5:0] OPC_ANDI = 6'h0C;
  localparam logic [5:0] OPC_ORI = 6'h0D;
  localparam logic [5:0] OPC_XORI = 6'h0E;
  localparam logic [5:0] OPC_ERET_DEF = 6'h10;
  localparam logic [5:0] OPC_LW = 6'h23;
  localparam logic [5:0] OPC_SW = 6'h2B;
  localparam logic [3:0] FETCH = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] R_EXEC = 4'd2;
  localparam logic [3:0] R_WB = 4'd3;
  localparam logic [3:0] I_EXEC = 4'd4;
  localparam logic [3:0] I_WB = 4'd5;
  localparam logic [3:0] MEM_ADDR = 4'd6;
  localparam logic [3:0] MEM_RD = 4'd7;
  localparam logic [3:0] MEM_WB = 4'd8;
  localparam logic [3:0] MEM_WR = 4'd9;
  localparam logic [3:0] BRANCH = 4'd10;
  localparam logic [3:0] JUMP = 4'd11;
  localparam logic [3:0] JAL = 4'd12;
  localparam logic [3:0] ERET = 4'd13;
  localparam logic [3:0] ILLEGAL = 4'd14;
  localparam logic [3:0] INT = 4'd15;
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] SRCB_B = 2'd0;
  localparam logic [1:0] SRCB_4 = 2'd1;
  localparam logic [1:0] SRCB_IMM = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;
  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_R31 = 2'd2;
  localparam logic [1:0] WD_ALUOUT = 2'd0;
  localparam logic [1:0] WD_MDR = 2'd1;
  localparam logic [1:0] WD_PC = 2'd2;
  localparam logic [2:0] PCS_ALU = 3'd0;
  localparam logic [2:0] PCS_ALUOUT = 3'd1;
  localparam logic [2:0] PCS_JUMP = 3'd2;
  localparam logic [2:0] PCS_VECTOR = 3'd3;
  localparam logic [2:0] PCS_SAVED = 3'd4;
  typedef struct packed {
    logic mem_read, mem_write, i_or_d, reg_write, ir_write, pc_write, pc_write_cond;
    logic alu_src_a, imm_com, int_save_pc, int_ack;
    logic [1:0] alu_op, alu_src_b, wreg_dst, wreg_data_sel;
    logic [2:0] pc_source;
  } ctrl_t;
  function automatic logic [3:0] decode_op(input logic [5:0] op, input logic [5:0] eret_op,
                                           input logic in_isr);
    if (op == eret_op) return in_isr ? ERET : ILLEGAL;
    case (op)
      OPC_RTYPE: return R_EXEC;
      OPC_LW, OPC_SW: return MEM_ADDR;
      OPC_BEQ: return BRANCH;
      OPC_J: return JUMP;
      OPC_JAL: return JAL;
      OPC_ADDI, OPC_SLTI, OPC_ANDI, OPC_ORI, OPC_XORI: return I_EXEC;
      default: return ILLEGAL;
    endcase
  endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bundle between the FSM (master) and the multicycle datapath (slave)
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic zero, int_req;
  logic [1:0] alu_op, alu_src_b, wreg_dst, wreg_data_sel;
  logic mem_read, mem_write, i_or_d, reg_write, ir_write, pc_write, pc_write_cond, alu_src_a, imm_com;
  logic int_save_pc, int_ack, in_isr;
  logic [2:0] pc_source;
  modport master (
    input opcode, zero, int_req,
    output alu_op, alu_src_b, wreg_dst, wreg_data_sel, mem_read, mem_write, i_or_d, reg_write,
      ir_write, pc_write, pc_write_cond, alu_src_a, imm_com, int_save_pc, pc_source, int_ack, in_isr
  );
  modport slave (
    output opcode, zero, int_req,
    input alu_op, alu_src_b, wreg_dst, wreg_data_sel, mem_read, mem_write, i_or_d, reg_write,
      ir_write, pc_write, pc_write_cond, alu_src_a, imm_com, int_save_pc, pc_source, int_ack, in_isr
  );
endinterface

// File: rtl/multicycle_ctrl_irq_sync.sv
// irq_sync: STAGES-deep synchroniser for the asynchronous interrupt request
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk) sync_q <= rst ? '0 : {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the multicycle MIPS datapath with interrupt entry/ERET.
// CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap like an interrupt instead of acting as a NOP.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int IRQ_SYNC_STAGES = 2,
  parameter logic [5:0] OPC_ERET = OPC_ERET_DEF
) (
  input logic clk,
  input logic rst,
  multicycle_ctrl_if.master bus
);
  logic [3:0] state_q, state_d;
  logic in_isr_q, in_isr_d, irq_s;
  ctrl_t c, o;
  irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .d_i(bus.int_req), .q_o(irq_s));
  always_comb begin
    state_d = FETCH;
    in_isr_d = in_isr_q;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: state_d = decode_op(bus.opcode, OPC_ERET, in_isr_q);
      R_EXEC: state_d = R_WB;
      I_EXEC: state_d = I_WB;
      MEM_ADDR: state_d = (bus.opcode == OPC_LW) ? MEM_RD : MEM_WR;
      MEM_RD: state_d = MEM_WB;
      INT: in_isr_d = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ILLEGAL: in_isr_d = 1'b1;
`endif
      // in_isr is cleared on this same edge, so a pending request may re-enter immediately
      ERET: begin
        in_isr_d = 1'b0;
        state_d = irq_s ? INT : FETCH;
      end
      default: state_d = (irq_s && !in_isr_q) ? INT : FETCH;
    endcase
  end
  always_comb begin
    c = '0;
    case (state_q)
      FETCH: begin
        c.mem_read = 1'b1;
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
        c.alu_src_b = SRCB_4;
        c.alu_op = ALU_ADD;
      end
      DECODE: c.alu_src_b = SRCB_IMM_SH;
      R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op = ALU_FUNCT;
      end
      R_WB: begin
        c.reg_write = 1'b1;
        c.wreg_dst = DST_RD;
      end
      I_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op = ALU_FUNCT;
        c.imm_com = 1'b1;
      end
      I_WB: begin
        c.reg_write = 1'b1;
        c.imm_com = 1'b1;
      end
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        c.mem_read = 1'b1;
        c.i_or_d = 1'b1;
      end
      MEM_WB: begin
        c.reg_write = 1'b1;
        c.wreg_data_sel = WD_MDR;
      end
      MEM_WR: begin
        c.mem_write = 1'b1;
        c.i_or_d = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source = PCS_ALUOUT;
      end
      JUMP: begin
        c.pc_write = 1'b1;
        c.pc_source = PCS_JUMP;
      end
      JAL: begin
        c.pc_write = 1'b1;
        c.pc_source = PCS_JUMP;
        c.reg_write = 1'b1;
        c.wreg_dst = DST_R31;
        c.wreg_data_sel = WD_PC;
      end
      ERET: begin
        c.pc_write = 1'b1;
        c.pc_source = PCS_SAVED;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      INT, ILLEGAL: begin
`else
      INT: begin
`endif
        c.int_save_pc = 1'b1;
        c.pc_write = 1'b1;
        c.pc_source = PCS_VECTOR;
        c.int_ack = 1'b1;
      end
      default: c = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? FETCH : state_d;
    in_isr_q <= rst ? 1'b0 : in_isr_d;
  end
  // a write already decoded must not reach the datapath while reset is held
  assign o = rst ? '0 : c;
  assign bus.mem_read = o.mem_read;
  assign bus.mem_write = o.mem_write;
  assign bus.i_or_d = o.i_or_d;
  assign bus.reg_write = o.reg_write;
  assign bus.ir_write = o.ir_write;
  assign bus.pc_write = o.pc_write;
  assign bus.pc_write_cond = o.pc_write_cond;
  assign bus.alu_src_a = o.alu_src_a;
  assign bus.imm_com = o.imm_com;
  assign bus.int_save_pc = o.int_save_pc;
  assign bus.int_ack = o.int_ack;
  assign bus.alu_op = o.alu_op;
  assign bus.alu_src_b = o.alu_src_b;
  assign bus.wreg_dst = o.wreg_dst;
  assign bus.wreg_data_sel = o.wreg_data_sel;
  assign bus.pc_source = o.pc_source;
  assign bus.in_isr = in_isr_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed checks of the control FSM against hand-derived per-state control vectors
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_err = 0;
  multicycle_ctrl_if dp ();
  multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(dp));
  always #5 clk = ~clk;
  // {mr,mw,iod,rw,irw,pcw,pcwc,asa,imm,isp,ack, alu_op, alu_src_b, wreg_dst, wreg_data_sel, pc_source}
  logic [21:0] ctl;
  assign ctl = {dp.mem_read, dp.mem_write, dp.i_or_d, dp.reg_write, dp.ir_write, dp.pc_write,
                dp.pc_write_cond, dp.alu_src_a, dp.imm_com, dp.int_save_pc, dp.int_ack,
                dp.alu_op, dp.alu_src_b, dp.wreg_dst, dp.wreg_data_sel, dp.pc_source};
  localparam logic [21:0] E_NONE = 22'd0;
  localparam logic [21:0] E_FETCH = {11'b10001100000, 2'd0, 2'd1, 2'd0, 2'd0, 3'd0};
  localparam logic [21:0] E_DEC = {11'b00000000000, 2'd0, 2'd3, 2'd0, 2'd0, 3'd0};
  localparam logic [21:0] E_RX = {11'b00000001000, 2'd2, 2'd0, 2'd0, 2'd0, 3'd0};
  localparam logic [21:0] E_RWB = {11'b00010000000, 2'd0, 2'd0, 2'd1, 2'd0, 3'd0};
  localparam logic [21:0] E_IX = {11'b00000001100, 2'd2, 2'd2, 2'd0, 2'd0, 3'd0};
  localparam logic [21:0] E_IWB = {11'b00010000100, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0};
  localparam logic [21:0] E_MADDR = {11'b00000001000, 2'd0, 2'd2, 2'd0, 2'd0, 3'd0};
  localparam logic [21:0] E_MRD = {11'b10100000000, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0};
  localparam logic [21:0] E_MWB = {11'b00010000000, 2'd0, 2'd0, 2'd0, 2'd1, 3'd0};
  localparam logic [21:0] E_MWR = {11'b01100000000, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0};
  localparam logic [21:0] E_BR = {11'b00000011000, 2'd1, 2'd0, 2'd0, 2'd0, 3'd1};
  localparam logic [21:0] E_J = {11'b00000100000, 2'd0, 2'd0, 2'd0, 2'd0, 3'd2};
  localparam logic [21:0] E_JAL = {11'b00010100000, 2'd0, 2'd0, 2'd2, 2'd2, 3'd2};
  localparam logic [21:0] E_ERET = {11'b00000100000, 2'd0, 2'd0, 2'd0, 2'd0, 3'd4};
  localparam logic [21:0] E_INT = {11'b00000100011, 2'd0, 2'd0, 2'd0, 2'd0, 3'd3};
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic [21:0] E_ILL = E_INT;
`else
  localparam logic [21:0] E_ILL = E_NONE;
`endif
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cyc(input string tag, input logic [21:0] exp);
    check(tag, {10'd0, ctl}, {10'd0, exp});
    tick();
  endtask
  task automatic run_eret(input string tag);
    dp.opcode = 6'h10;
    cyc({tag, "_f"}, E_FETCH);
    cyc({tag, "_d"}, E_DEC);
    check({tag, "_isr_in"}, {31'd0, dp.in_isr}, 32'd1);
    cyc({tag, "_eret"}, E_ERET);
    check({tag, "_isr_out"}, {31'd0, dp.in_isr}, 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    dp.opcode = 6'h00;
    dp.zero = 1'b0;
    dp.int_req = 1'b0;
    repeat (3) tick();
    check("rst_ctl", {10'd0, ctl}, 32'd0);
    check("rst_isr", {31'd0, dp.in_isr}, 32'd0);
    rst = 1'b0;
    #1;
    dp.opcode = 6'h23;
    cyc("lw_f", E_FETCH);
    cyc("lw_d", E_DEC);
    cyc("lw_a", E_MADDR);
    cyc("lw_r", E_MRD);
    cyc("lw_wb", E_MWB);
    dp.opcode = 6'h03;
    cyc("jal_f", E_FETCH);
    cyc("jal_d", E_DEC);
    cyc("jal_x", E_JAL);
    dp.opcode = 6'h0D;
    cyc("ori_f", E_FETCH);
    cyc("ori_d", E_DEC);
    cyc("ori_x", E_IX);
    cyc("ori_wb", E_IWB);
    dp.opcode = 6'h04;
    cyc("beq_f", E_FETCH);
    cyc("beq_d", E_DEC);
    cyc("beq_x", E_BR);
    dp.opcode = 6'h2B;
    cyc("sw_f", E_FETCH);
    cyc("sw_d", E_DEC);
    cyc("sw_a", E_MADDR);
    cyc("sw_w", E_MWR);
    dp.opcode = 6'h00;
    dp.int_req = 1'b1;
    cyc("r_f", E_FETCH);
    cyc("r_d", E_DEC);
    cyc("r_x", E_RX);
    cyc("r_wb", E_RWB);
    check("int_isr_pre", {31'd0, dp.in_isr}, 32'd0);
    cyc("int", E_INT);
    check("int_isr_set", {31'd0, dp.in_isr}, 32'd1);
    dp.opcode = 6'h02;
    cyc("isr_j_f", E_FETCH);
    cyc("isr_j_d", E_DEC);
    cyc("isr_j_x", E_J);
    check("isr_masked", {10'd0, ctl}, {10'd0, E_FETCH});
    dp.int_req = 1'b0;
    run_eret("eret");
    dp.opcode = 6'h10;
    cyc("eret_noisr_f", E_FETCH);
    cyc("eret_noisr_d", E_DEC);
    cyc("eret_noisr_ill", E_ILL);
`ifdef CTRL_ILLEGAL_TRAP_EN
    run_eret("eret_t1");
`else
    check("eret_noisr_isr", {31'd0, dp.in_isr}, 32'd0);
`endif
    dp.opcode = 6'h3F;
    cyc("ill_f", E_FETCH);
    cyc("ill_d", E_DEC);
    cyc("ill_x", E_ILL);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check("ill_isr", {31'd0, dp.in_isr}, 32'd1);
    run_eret("eret_t2");
`else
    check("ill_isr", {31'd0, dp.in_isr}, 32'd0);
`endif
    dp.opcode = 6'h23;
    dp.int_req = 1'b1;
    cyc("pulse_f", E_FETCH);
    dp.int_req = 1'b0;
    cyc("pulse_d", E_DEC);
    cyc("pulse_a", E_MADDR);
    cyc("pulse_r", E_MRD);
    cyc("pulse_wb", E_MWB);
    check("pulse_noint", {10'd0, ctl}, {10'd0, E_FETCH});
    check("pulse_isr", {31'd0, dp.in_isr}, 32'd0);
    dp.opcode = 6'h2B;
    cyc("swr_f", E_FETCH);
    cyc("swr_d", E_DEC);
    check("swr_a", {10'd0, ctl}, {10'd0, E_MADDR});
    rst = 1'b1;
    #1;
    check("swr_rst_ctl", {10'd0, ctl}, 32'd0);
    tick();
    check("swr_rst_mw", {31'd0, dp.mem_write}, 32'd0);
    rst = 1'b0;
    #1;
    cyc("swr_fetch", E_FETCH);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
